// File: rtl/vend_session_ctrl_pkg.sv
// Shared definitions for the two-panel vending session controller:
// product prices, credit ceiling, FSM encoding and small decode helpers.
package vend_session_ctrl_pkg;

    localparam logic [5:0] PRICE_1    = 6'd5;
    localparam logic [5:0] PRICE_2    = 6'd10;
    localparam logic [5:0] PRICE_3    = 6'd20;
    localparam logic [5:0] MAX_CREDIT = 6'd40;

    localparam logic [4:0] COIN_5  = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_20 = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_VEND   = 2'b01,
        ST_CHANGE = 2'b10
    } state_e;

    function automatic logic [5:0] price_of(input logic [1:0] code);
        logic [5:0] p;
        case (code)
            2'b01:   p = PRICE_1;
            2'b10:   p = PRICE_2;
            2'b11:   p = PRICE_3;
            default: p = 6'd0;
        endcase
        return p;
    endfunction

    function automatic logic coin_legal(input logic [4:0] val);
        return (val == COIN_5) || (val == COIN_10) || (val == COIN_20);
    endfunction

endpackage

// File: rtl/vend_session_ctrl_if.sv
// Panel-side bus of the vending session controller: per-panel requests in,
// reject pulses and dispenser commands out.
interface vend_session_ctrl_if;
    logic [1:0] coin_valid;
    logic [4:0] coin_val0;
    logic [4:0] coin_val1;
    logic [1:0] sel_valid;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic [1:0] cancel;
    logic [1:0] coin_reject;
    logic [1:0] sel_reject;
    logic [1:0] grant;
    logic       vend_strobe;
    logic [1:0] vend_product;
    logic       change_valid;
    logic [5:0] change;
    logic       busy;

    modport master (
        output coin_valid, coin_val0, coin_val1, sel_valid, sel0, sel1, cancel,
        input  coin_reject, sel_reject, grant, vend_strobe, vend_product,
               change_valid, change, busy
    );

    modport slave (
        input  coin_valid, coin_val0, coin_val1, sel_valid, sel0, sel1, cancel,
        output coin_reject, sel_reject, grant, vend_strobe, vend_product,
               change_valid, change, busy
    );
endinterface

// File: rtl/vend_session_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the panel that was not served last wins.
module vend_rr_arbiter (
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       enable,
    output logic [1:0] gnt
);

    // One-hot grant, suppressed while the dispenser is busy
    always_comb begin
        if (!enable) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = rr_last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/vend_session_ctrl.sv
// Shares one dispense path between two coin panels: per-panel credit and
// request capture, round-robin service, vend strobe then change return.
module vend_session_ctrl
    import vend_session_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    vend_session_ctrl_if.slave bus
);

    logic [5:0] credit_q [2];
    logic [5:0] credit_d [2];
    logic [1:0] pend_prod_q [2];
    logic [1:0] pend_prod_d [2];
    logic [4:0] coin_val_s [2];
    logic [1:0] sel_s [2];
    logic [6:0] sum_s [2];
    logic [1:0] pend_q, pend_d, pend_refund_q, pend_refund_d;
    logic [1:0] cancel_acc_s, sel_acc_s, coin_acc_s, clr_s;
    logic [1:0] coin_reject_q, coin_reject_d, sel_reject_q, sel_reject_d;

    state_e     state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic [1:0] grant_q, grant_d, gnt_s;
    logic       win_s;
    logic       vend_strobe_q, vend_strobe_d;
    logic [1:0] vend_product_q, vend_product_d;
    logic       change_valid_q, change_valid_d;
    logic [5:0] change_q, change_d;
    logic       busy_q, busy_d;

    assign coin_val_s[0] = bus.coin_val0;
    assign coin_val_s[1] = bus.coin_val1;
    assign sel_s[0]      = bus.sel0;
    assign sel_s[1]      = bus.sel1;

    // Per-panel credit accumulation and request capture; credit freezes once pending
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sum_s[i]        = {1'b0, credit_q[i]} + {2'b00, coin_val_s[i]};
            cancel_acc_s[i] = bus.cancel[i] && !pend_q[i] && (credit_q[i] != 6'd0);
            sel_acc_s[i]    = bus.sel_valid[i] && (sel_s[i] != 2'b00) && !pend_q[i]
                              && (credit_q[i] >= price_of(sel_s[i])) && !cancel_acc_s[i];
            coin_acc_s[i]   = bus.coin_valid[i] && coin_legal(coin_val_s[i]) && !pend_q[i]
                              && (sum_s[i] <= {1'b0, MAX_CREDIT}) && !sel_acc_s[i];
            coin_reject_d[i] = bus.coin_valid[i] && !coin_acc_s[i];
            sel_reject_d[i]  = bus.sel_valid[i] && !sel_acc_s[i];
            if (clr_s[i]) begin
                credit_d[i]      = 6'd0;
                pend_d[i]        = 1'b0;
                pend_refund_d[i] = 1'b0;
                pend_prod_d[i]   = 2'b00;
            end else begin
                credit_d[i] = coin_acc_s[i] ? sum_s[i][5:0] : credit_q[i];
                if (cancel_acc_s[i]) begin
                    pend_d[i]        = 1'b1;
                    pend_refund_d[i] = 1'b1;
                    pend_prod_d[i]   = 2'b00;
                end else if (sel_acc_s[i]) begin
                    pend_d[i]        = 1'b1;
                    pend_refund_d[i] = 1'b0;
                    pend_prod_d[i]   = sel_s[i];
                end else begin
                    pend_d[i]        = pend_q[i];
                    pend_refund_d[i] = pend_refund_q[i];
                    pend_prod_d[i]   = pend_prod_q[i];
                end
            end
        end
    end

    // Panel state and reject pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                credit_q[i]    <= 6'd0;
                pend_prod_q[i] <= 2'b00;
            end
            pend_q        <= 2'b00;
            pend_refund_q <= 2'b00;
            coin_reject_q <= 2'b00;
            sel_reject_q  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                credit_q[i]    <= credit_d[i];
                pend_prod_q[i] <= pend_prod_d[i];
            end
            pend_q        <= pend_d;
            pend_refund_q <= pend_refund_d;
            coin_reject_q <= coin_reject_d;
            sel_reject_q  <= sel_reject_d;
        end
    end

    vend_rr_arbiter u_arb (
        .req     (pend_q),
        .rr_last (rr_last_q),
        .enable  (state_q == ST_IDLE),
        .gnt     (gnt_s)
    );

    // FSM state register together with the latched owner and round-robin history
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next-state: refunds skip the vend step
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    grant_d   = gnt_s;
                    rr_last_d = gnt_s[1];
                    state_d   = pend_refund_q[gnt_s[1]] ? ST_CHANGE : ST_VEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VEND:   state_d = ST_CHANGE;
            ST_CHANGE: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        win_s          = (state_q == ST_IDLE) ? gnt_s[1] : grant_q[1];
        vend_strobe_d  = (state_d == ST_VEND);
        vend_product_d = (state_d == ST_VEND) ? pend_prod_q[win_s] : 2'b00;
        change_valid_d = (state_d == ST_CHANGE);
        if (state_d != ST_CHANGE) begin
            change_d = 6'd0;
        end else if (pend_refund_q[win_s]) begin
            change_d = credit_q[win_s];
        end else begin
            change_d = credit_q[win_s] - price_of(pend_prod_q[win_s]);
        end
        busy_d = (state_d != ST_IDLE);
        clr_s  = (state_q == ST_CHANGE) ? grant_q : 2'b00;
    end

    // Dispenser command registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            vend_strobe_q  <= 1'b0;
            vend_product_q <= 2'b00;
            change_valid_q <= 1'b0;
            change_q       <= 6'd0;
            busy_q         <= 1'b0;
        end else begin
            vend_strobe_q  <= vend_strobe_d;
            vend_product_q <= vend_product_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_reject   = sel_reject_q;
    assign bus.grant        = grant_q;
    assign bus.vend_strobe  = vend_strobe_q;
    assign bus.vend_product = vend_product_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change       = change_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Bench for vend_session_ctrl: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a transaction-level model.
module tb_vend_session_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vend_session_ctrl_if bus();

    vend_session_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: panel wallets plus a queue of scheduled dispenser actions
    typedef struct {
        int kind;   // 1 vend, 2 change, 3 release
        int panel;
        int prod;
        int amt;
    } ev_t;

    ev_t evq[$];
    int  m_credit [2];
    int  m_pend   [2];
    int  m_ref    [2];
    int  m_prod   [2];
    int  m_rr_last;
    int  e_coin_rej, e_sel_rej, e_grant, e_strobe, e_prod, e_cv, e_change, e_busy;

    logic [4:0] coin_tab [11] = '{5'd5, 5'd10, 5'd20, 5'd5, 5'd10, 5'd20,
                                  5'd0, 5'd7, 5'd15, 5'd25, 5'd31};

    function automatic int price(input int code);
        case (code)
            1:       return 5;
            2:       return 10;
            3:       return 20;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                              input logic [1:0] sv, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] can, input logic rst);
        ev_t e;
        int  w;
        int  clr;
        int  val, code, can_ok, sel_ok, coin_ok;
        e_coin_rej = 0; e_sel_rej = 0; e_grant = 0; e_strobe = 0;
        e_prod = 0; e_cv = 0; e_change = 0; e_busy = 0;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                m_credit[p] = 0; m_pend[p] = 0; m_ref[p] = 0; m_prod[p] = 0;
            end
            evq.delete();
            m_rr_last = 1;
            return;
        end
        clr = -1;
        if (evq.size() == 0) begin
            w = -1;
            if (m_pend[0] != 0 && m_pend[1] != 0) w = (m_rr_last == 0) ? 1 : 0;
            else if (m_pend[0] != 0) w = 0;
            else if (m_pend[1] != 0) w = 1;
            if (w >= 0) begin
                m_rr_last = w;
                if (m_ref[w] == 0) evq.push_back('{1, w, m_prod[w], 0});
                evq.push_back('{2, w, 0, (m_ref[w] != 0) ? m_credit[w]
                                                         : m_credit[w] - price(m_prod[w])});
                evq.push_back('{3, w, 0, 0});
            end
        end
        if (evq.size() > 0) begin
            e = evq.pop_front();
            if (e.kind == 1) begin
                e_grant = 1 << e.panel; e_strobe = 1; e_prod = e.prod; e_busy = 1;
            end else if (e.kind == 2) begin
                e_grant = 1 << e.panel; e_cv = 1; e_change = e.amt; e_busy = 1;
            end else begin
                clr = e.panel;
            end
        end
        for (int p = 0; p < 2; p++) begin
            val     = (p == 0) ? int'(c0) : int'(c1);
            code    = (p == 0) ? int'(s0) : int'(s1);
            can_ok  = (can[p] && m_pend[p] == 0 && m_credit[p] > 0) ? 1 : 0;
            sel_ok  = (sv[p] && code != 0 && m_pend[p] == 0 && m_credit[p] >= price(code)
                       && can_ok == 0) ? 1 : 0;
            coin_ok = (cv[p] && (val == 5 || val == 10 || val == 20) && m_pend[p] == 0
                       && m_credit[p] + val <= 40 && sel_ok == 0) ? 1 : 0;
            if (cv[p] && coin_ok == 0) e_coin_rej |= (1 << p);
            if (sv[p] && sel_ok == 0)  e_sel_rej  |= (1 << p);
            if (coin_ok != 0) m_credit[p] += val;
            if (can_ok != 0) begin
                m_pend[p] = 1; m_ref[p] = 1;
            end else if (sel_ok != 0) begin
                m_pend[p] = 1; m_prod[p] = code;
            end
        end
        if (clr >= 0) begin
            m_credit[clr] = 0; m_pend[clr] = 0; m_ref[clr] = 0; m_prod[clr] = 0;
        end
    endtask

    task automatic compare_all();
        chk("coin_reject",  int'(bus.coin_reject),  e_coin_rej);
        chk("sel_reject",   int'(bus.sel_reject),   e_sel_rej);
        chk("grant",        int'(bus.grant),        e_grant);
        chk("vend_strobe",  int'(bus.vend_strobe),  e_strobe);
        chk("vend_product", int'(bus.vend_product), e_prod);
        chk("change_valid", int'(bus.change_valid), e_cv);
        chk("change",       int'(bus.change),       e_change);
        chk("busy",         int'(bus.busy),         e_busy);
    endtask

    // drive one cycle of inputs at the falling edge, then check after the rising edge
    task automatic step(input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                        input logic [1:0] sv, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] can, input logic rst);
        bus.coin_valid = cv; bus.coin_val0 = c0; bus.coin_val1 = c1;
        bus.sel_valid = sv; bus.sel0 = s0; bus.sel1 = s1;
        bus.cancel = can; reset = rst;
        model_step(cv, c0, c1, sv, s0, s1, can, rst);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    endtask

    task automatic do_reset();
        step(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic coin(input logic p, input logic [4:0] v);
        step(p ? 2'b10 : 2'b01, p ? 5'd0 : v, p ? v : 5'd0,
             2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    endtask

    task automatic sel(input logic p, input logic [1:0] c);
        step(2'b00, 5'd0, 5'd0, p ? 2'b10 : 2'b01, p ? 2'b00 : c, p ? c : 2'b00,
             2'b00, 1'b1);
    endtask

    task automatic cancel(input logic p);
        step(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, p ? 2'b10 : 2'b01, 1'b1);
    endtask

    initial begin
        logic [1:0] cv, sv, can, s0, s1;
        logic [4:0] c0, c1;
        logic       rst;
        bus.coin_valid = 2'b00; bus.coin_val0 = 5'd0; bus.coin_val1 = 5'd0;
        bus.sel_valid = 2'b00; bus.sel0 = 2'b00; bus.sel1 = 2'b00; bus.cancel = 2'b00;
        @(negedge clk);

        do_reset();
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_busy",  int'(bus.busy), 0);

        // 1: coin 5, product 1 -> vend then zero change
        coin(1'b0, 5'd5);
        sel(1'b0, 2'b01);
        idle(1);
        chk("t1_strobe", int'(bus.vend_strobe), 1);
        chk("t1_prod",   int'(bus.vend_product), 1);
        chk("t1_grant",  int'(bus.grant), 1);
        idle(1);
        chk("t1_cv",     int'(bus.change_valid), 1);
        chk("t1_change", int'(bus.change), 0);
        idle(1);
        chk("t1_idle",   int'(bus.busy), 0);

        // 2: 20+20, product 2 -> change 30, wallet empty afterwards
        coin(1'b0, 5'd20);
        coin(1'b0, 5'd20);
        sel(1'b0, 2'b10);
        idle(1);
        chk("t2_prod",   int'(bus.vend_product), 2);
        idle(1);
        chk("t2_change", int'(bus.change), 30);
        idle(1);
        sel(1'b0, 2'b01);
        chk("t2_empty",  int'(bus.sel_reject), 1);

        // 3: ceiling, illegal coin, insufficient credit
        coin(1'b0, 5'd20);
        coin(1'b0, 5'd20);
        coin(1'b0, 5'd5);
        chk("t3_ceiling", int'(bus.coin_reject), 1);
        coin(1'b0, 5'd7);
        chk("t3_illegal", int'(bus.coin_reject), 1);
        cancel(1'b0);
        idle(1);
        chk("t3_refund40", int'(bus.change), 40);
        idle(1);
        coin(1'b0, 5'd5);
        sel(1'b0, 2'b11);
        chk("t3_short", int'(bus.sel_reject), 1);
        do_reset();

        // 4: simultaneous requests served round-robin
        step(2'b11, 5'd5, 5'd5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b00, 5'd0, 5'd0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b1);
        idle(1);
        chk("t4_first",  int'(bus.grant), 1);
        idle(3);
        chk("t4_second", int'(bus.grant), 2);
        idle(3);
        step(2'b11, 5'd5, 5'd5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b00, 5'd0, 5'd0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b1);
        idle(1);
        chk("t4_third",  int'(bus.grant), 1);
        idle(6);

        // 5: refunds, cancel wins over select
        coin(1'b1, 5'd5);
        coin(1'b1, 5'd10);
        cancel(1'b1);
        idle(1);
        chk("t5_nostrobe", int'(bus.vend_strobe), 0);
        chk("t5_change",   int'(bus.change), 15);
        chk("t5_grant",    int'(bus.grant), 2);
        idle(1);
        coin(1'b1, 5'd10);
        step(2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1);
        idle(1);
        chk("t5_cancel_wins", int'(bus.change), 10);
        idle(1);

        // 6: reset during vend aborts the session
        coin(1'b0, 5'd10);
        sel(1'b0, 2'b01);
        idle(1);
        chk("t6_strobe", int'(bus.vend_strobe), 1);
        do_reset();
        chk("t6_abort_grant", int'(bus.grant), 0);
        chk("t6_abort_busy",  int'(bus.busy), 0);
        idle(1);
        chk("t6_no_change",   int'(bus.change_valid), 0);
        sel(1'b0, 2'b01);
        chk("t6_credit_gone", int'(bus.sel_reject), 1);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cv[0] = ($urandom_range(0, 99) < 40);
            cv[1] = ($urandom_range(0, 99) < 40);
            c0    = coin_tab[$urandom_range(0, 10)];
            c1    = coin_tab[$urandom_range(0, 10)];
            sv[0] = ($urandom_range(0, 99) < 20);
            sv[1] = ($urandom_range(0, 99) < 20);
            s0    = 2'($urandom_range(0, 3));
            s1    = 2'($urandom_range(0, 3));
            can[0] = ($urandom_range(0, 99) < 6);
            can[1] = ($urandom_range(0, 99) < 6);
            rst   = ($urandom_range(0, 299) != 0);
            step(cv, c0, c1, sv, s0, s1, can, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
